// File: rtl/divider_sequencer.sv
// ---------------------------------------------------------------------------
// divider_sequencer
//
// Drives one 8-bit 74191-style up/down counter-divider through a small
// table of (divide value, direction, repeat count) entries.  Each entry is
// played as: load the counter, enable it, count terminal-count pulses until
// the entry's repeat count is reached, then advance.  The result is a
// variable-frequency pulse schedule produced by a single divider instance.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   cfg_we       table write strobe (ignored while busy)
//   cfg_addr     table entry index
//   cfg_div      divide/load value for the entry (0 = skip the entry)
//   cfg_dir      entry DownUp value (0 = up, 1 = down)
//   cfg_rep      terminal-count events per entry (0 behaves as 1)
//   last_step    index of the final entry played (sampled live)
//   loop         1 = restart at entry 0 after last_step (sampled live)
//   start        begin a sequence (level, sampled in IDLE only)
//   abort        return to IDLE on the next edge, highest priority
//   cnt_tc       counter terminal-count pulse
//   cnt_data     load value to the counter
//   cnt_load_n   counter load, active-low
//   cnt_en_n     counter enable (GN), active-low
//   cnt_down_up  counter direction
//   step_idx     entry currently played
//   tick         one-cycle pulse per accepted cnt_tc
//   busy         sequence in progress
//   done         one-cycle completion pulse
//   dbg_state    current FSM state (IDLE=0 LOAD=1 RUN=2 NEXT=3 DONE=4)
//
// Handshake: there is no valid/ready pair here.  cfg_we is a single-cycle
// write qualified by busy=0; start is a level accepted only in IDLE; cnt_tc
// is a single-cycle pulse accepted only in RUN.  Every output is a flop.
// ---------------------------------------------------------------------------
module divider_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 2,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [DEPTH_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]   cfg_div,
    input  logic               cfg_dir,
    input  logic [REP_W-1:0]   cfg_rep,
    input  logic [DEPTH_W-1:0] last_step,
    input  logic               loop,
    input  logic               start,
    input  logic               abort,
    input  logic               cnt_tc,
    output logic [WIDTH-1:0]   cnt_data,
    output logic               cnt_load_n,
    output logic               cnt_en_n,
    output logic               cnt_down_up,
    output logic [DEPTH_W-1:0] step_idx,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    localparam int DEPTH = 1 << DEPTH_W;

    localparam logic [DEPTH_W-1:0] STEP_ZERO = '0;
    localparam logic [DEPTH_W-1:0] STEP_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0]   REP_ZERO  = '0;
    localparam logic [REP_W-1:0]   REP_ONE   = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   DIV_ZERO  = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;

    // Entry table
    logic [WIDTH-1:0] div_tbl [DEPTH];
    logic             dir_tbl [DEPTH];
    logic [REP_W-1:0] rep_tbl [DEPTH];

    // Terminal-count events accepted for the current entry
    logic [REP_W-1:0] rep_cnt;

    // Combinational helpers
    logic [WIDTH-1:0]   cur_div;
    logic [REP_W-1:0]   rep_target;
    logic [REP_W-1:0]   rep_cnt_inc;
    logic [DEPTH_W-1:0] nxt_step;
    logic [WIDTH-1:0]   nxt_div;
    logic               nxt_dir;
    logic               advance;

    // ------------------------------------------------------------------
    // Table storage.  Writes are locked out for the whole sequence so the
    // entry being played can never change underneath the FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                div_tbl[i] <= DIV_ZERO;
                dir_tbl[i] <= 1'b0;
                rep_tbl[i] <= REP_ZERO;
            end
        end else if (cfg_we && !busy) begin
            div_tbl[cfg_addr] <= cfg_div;
            dir_tbl[cfg_addr] <= cfg_dir;
            rep_tbl[cfg_addr] <= cfg_rep;
        end
    end

    // ------------------------------------------------------------------
    // Next-entry selection and per-entry targets
    // ------------------------------------------------------------------
    always_comb begin
        cur_div     = div_tbl[step_idx];
        // A repeat count of zero would never terminate; play it once.
        rep_target  = (rep_tbl[step_idx] == REP_ZERO) ? REP_ONE : rep_tbl[step_idx];
        rep_cnt_inc = rep_cnt + REP_ONE;

        // Leaving NEXT for another LOAD happens either by stepping forward
        // or by wrapping to entry 0 when looping at the final entry.
        advance  = (step_idx != last_step) || loop;
        nxt_step = (step_idx != last_step) ? (step_idx + STEP_ONE) : STEP_ZERO;
        nxt_div  = div_tbl[nxt_step];
        nxt_dir  = dir_tbl[nxt_step];
    end

    // ------------------------------------------------------------------
    // Sequencer FSM.  Outputs are assigned together with the transition
    // into the state they belong to, so they are valid for the whole
    // cycle spent in that state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt_data    <= DIV_ZERO;
            cnt_load_n  <= 1'b1;
            cnt_en_n    <= 1'b1;
            cnt_down_up <= 1'b0;
            step_idx    <= STEP_ZERO;
            rep_cnt     <= REP_ZERO;
            tick        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // Pulses default low every cycle
            tick <= 1'b0;
            done <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abort wins over start, cnt_tc and any transition; the
                // data/direction lines are left at their last values.
                state      <= S_IDLE;
                cnt_load_n <= 1'b1;
                cnt_en_n   <= 1'b1;
                step_idx   <= STEP_ZERO;
                rep_cnt    <= REP_ZERO;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        cnt_en_n   <= 1'b1;
                        cnt_load_n <= 1'b1;
                        if (start) begin
                            state       <= S_LOAD;
                            step_idx    <= STEP_ZERO;
                            rep_cnt     <= REP_ZERO;
                            busy        <= 1'b1;
                            cnt_load_n  <= 1'b0;
                            cnt_data    <= div_tbl[STEP_ZERO];
                            cnt_down_up <= dir_tbl[STEP_ZERO];
                        end
                    end

                    S_LOAD: begin
                        cnt_load_n <= 1'b1;
                        if (cur_div == DIV_ZERO) begin
                            // Empty entry: pass straight through without
                            // ever enabling the counter.
                            state    <= S_NEXT;
                            cnt_en_n <= 1'b1;
                        end else begin
                            state    <= S_RUN;
                            cnt_en_n <= 1'b0;
                        end
                    end

                    S_RUN: begin
                        // The counter reloads itself on terminal count, so
                        // this state only counts the events.
                        if (cnt_tc) begin
                            tick    <= 1'b1;
                            rep_cnt <= rep_cnt_inc;
                            if (rep_cnt_inc == rep_target) begin
                                state    <= S_NEXT;
                                cnt_en_n <= 1'b1;
                            end
                        end
                    end

                    S_NEXT: begin
                        cnt_en_n <= 1'b1;
                        rep_cnt  <= REP_ZERO;
                        if (advance) begin
                            state       <= S_LOAD;
                            step_idx    <= nxt_step;
                            cnt_load_n  <= 1'b0;
                            cnt_data    <= nxt_div;
                            cnt_down_up <= nxt_dir;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state      <= S_IDLE;
                        cnt_load_n <= 1'b1;
                        cnt_en_n   <= 1'b1;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_divider_sequencer.sv
// ---------------------------------------------------------------------------
// tb_divider_sequencer
//
// Table-driven runs of whole sequences plus hand-written sequences for reset,
// exact latencies, skip/rep=0, loop with abort, config lockout and a
// mid-sequence reset.  Every observed LOAD cycle is popped from exp_q and
// compared against the entry the bench itself programmed.
// ---------------------------------------------------------------------------
module tb_divider_sequencer;

  localparam int WIDTH   = 8;
  localparam int DEPTH_W = 2;
  localparam int REP_W   = 4;
  localparam int W       = DEPTH_W + WIDTH + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [DEPTH_W-1:0] cfg_addr;
  logic [WIDTH-1:0]   cfg_div;
  logic               cfg_dir;
  logic [REP_W-1:0]   cfg_rep;
  logic [DEPTH_W-1:0] last_step;
  logic               loop;
  logic               start;
  logic               abort;
  logic               cnt_tc;
  logic [WIDTH-1:0]   cnt_data;
  logic               cnt_load_n;
  logic               cnt_en_n;
  logic               cnt_down_up;
  logic [DEPTH_W-1:0] step_idx;
  logic               tick;
  logic               busy;
  logic               done;
  logic [2:0]         dbg_state;

  divider_sequencer #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div), .cfg_dir(cfg_dir), .cfg_rep(cfg_rep),
    .last_step(last_step), .loop(loop), .start(start), .abort(abort), .cnt_tc(cnt_tc),
    .cnt_data(cnt_data), .cnt_load_n(cnt_load_n), .cnt_en_n(cnt_en_n), .cnt_down_up(cnt_down_up),
    .step_idx(step_idx), .tick(tick), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int tick_seen = 0;
  int done_seen = 0;
  int load_seen = 0;
  logic [W-1:0] exp_q[$];

  // Shadow of what the bench has written into the table
  logic [WIDTH-1:0] sh_div [4];
  logic             sh_dir [4];
  logic [REP_W-1:0] sh_rep [4];

  typedef struct {
    logic [3:0][WIDTH-1:0] div;
    logic [3:0]            dir;
    logic [3:0][REP_W-1:0] rep;
    logic [DEPTH_W-1:0]    last;
    logic                  hold;
    int                    exp_ticks;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    if (cnt_load_n === 1'b0) begin
      load_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL load_unexpected: step %0d data 0x%0h with no load required", step_idx, cnt_data);
      end else begin
        e = exp_q.pop_front();
        check("load_record{step,data,dir}", {21'd0, step_idx, cnt_data, cnt_down_up}, {21'd0, e});
      end
    end
    if (tick === 1'b1) tick_seen++;
    if (done === 1'b1) done_seen++;
    if (cnt_en_n === 1'b0) begin
      check("enabled_with_nonzero_div", {31'd0, cnt_data != '0}, 32'd1);
      check("enabled_load_high", {31'd0, cnt_load_n}, 32'd1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_entry(input logic [DEPTH_W-1:0] a, input logic [WIDTH-1:0] d,
                             input logic r, input logic [REP_W-1:0] rp, input bit shadow);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_div  = d;
    cfg_dir  = r;
    cfg_rep  = rp;
    cycle();
    cfg_we = 1'b0;
    if (shadow) begin
      sh_div[a] = d;
      sh_dir[a] = r;
      sh_rep[a] = rp;
    end
  endtask

  task automatic push_load(input logic [DEPTH_W-1:0] a);
    exp_q.push_back({a, sh_div[a], sh_dir[a]});
  endtask

  // Raise start, then act as the counter: random terminal counts while
  // enabled and stray ones while not, until done or the budget runs out.
  task automatic run_until_done(input string name, input bit hold, input int budget);
    bit finished;
    finished = 1'b0;
    start = 1'b1;
    for (int c = 0; c < budget && !finished; c++) begin
      cycle();
      if (done === 1'b1) begin
        finished = 1'b1;
        start = 1'b0;
      end else if (!hold) begin
        start = 1'b0;
      end
      cnt_tc = (cnt_en_n === 1'b0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
    end
    start  = 1'b0;
    cnt_tc = 1'b0;
    check({name, "_finished"}, {31'd0, finished}, 32'd1);
    cycle();
    check({name, "_busy_low_after"}, {31'd0, busy}, 32'd0);
    check({name, "_idle_after"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
  endtask

  task automatic run_vec(input int k);
    int t0, d0, l0;
    for (int s = 0; s < 4; s++)
      write_entry(DEPTH_W'(s), vecs[k].div[s], vecs[k].dir[s], vecs[k].rep[s], 1'b1);
    last_step = vecs[k].last;
    loop      = 1'b0;
    for (int s = 0; s <= int'(vecs[k].last); s++) push_load(DEPTH_W'(s));
    t0 = tick_seen; d0 = done_seen; l0 = load_seen;
    run_until_done($sformatf("vec%0d", k), vecs[k].hold, 3000);
    check($sformatf("vec%0d_ticks", k), tick_seen - t0, vecs[k].exp_ticks);
    check($sformatf("vec%0d_dones", k), done_seen - d0, 1);
    check($sformatf("vec%0d_loads", k), load_seen - l0, int'(vecs[k].last) + 1);
    check($sformatf("vec%0d_queue_empty", k), exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    int t0, d0, l0;
    bit reached;

    // Vector table: {div[3:0], dir[3:0], rep[3:0], last_step, hold start, expected ticks}
    vecs[0] = '{div: {8'h00, 8'h00, 8'h00, 8'h8F}, dir: 4'b0000, rep: {4'd0, 4'd0, 4'd0, 4'd3},
                last: 2'd0, hold: 1'b0, exp_ticks: 3};
    vecs[1] = '{div: {8'h00, 8'h30, 8'h20, 8'h10}, dir: 4'b0010, rep: {4'd0, 4'd1, 4'd2, 4'd1},
                last: 2'd2, hold: 1'b1, exp_ticks: 4};
    vecs[2] = '{div: {8'h00, 8'h30, 8'h00, 8'h10}, dir: 4'b0100, rep: {4'd0, 4'd0, 4'd5, 4'd2},
                last: 2'd2, hold: 1'b0, exp_ticks: 3};
    vecs[3] = '{div: {8'h00, 8'h80, 8'hFF, 8'h01}, dir: 4'b1101, rep: {4'd3, 4'd2, 4'd1, 4'd15},
                last: 2'd3, hold: 1'b0, exp_ticks: 18};
    vecs[4] = '{div: {8'h88, 8'h77, 8'h66, 8'h55}, dir: 4'b1010, rep: {4'd9, 4'd9, 4'd0, 4'd0},
                last: 2'd1, hold: 1'b1, exp_ticks: 2};

    for (int i = 0; i < 4; i++) begin
      sh_div[i] = '0; sh_dir[i] = 1'b0; sh_rep[i] = '0;
    end

    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_div = '0; cfg_dir = 1'b0; cfg_rep = '0;
    last_step = '0; loop = 1'b0; start = 1'b1; abort = 1'b0; cnt_tc = 1'b0;

    // Reset held with start high
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("rst_en_n", {31'd0, cnt_en_n}, 32'd1);
      check("rst_load_n", {31'd0, cnt_load_n}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    check("rst_cnt_data", {24'd0, cnt_data}, 32'd0);
    check("rst_down_up", {31'd0, cnt_down_up}, 32'd0);
    check("rst_step_idx", {30'd0, step_idx}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    start = 1'b0;
    rst   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("post_rst_quiet_load_n", {31'd0, cnt_load_n}, 32'd1);
      check("post_rst_quiet_busy", {31'd0, busy}, 32'd0);
    end

    // Single step with exact cycle timing
    write_entry(2'd0, 8'h8F, 1'b0, 4'd3, 1'b1);
    last_step = 2'd0; loop = 1'b0;
    push_load(2'd0);
    t0 = tick_seen;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("ss_load_n_low", {31'd0, cnt_load_n}, 32'd0);
    check("ss_data", {24'd0, cnt_data}, 32'h8F);
    check("ss_busy", {31'd0, busy}, 32'd1);
    check("ss_en_n_in_load", {31'd0, cnt_en_n}, 32'd1);
    cycle();
    check("ss_run_state", {29'd0, dbg_state}, {29'd0, ST_RUN});
    check("ss_run_en_n", {31'd0, cnt_en_n}, 32'd0);
    check("ss_run_load_n", {31'd0, cnt_load_n}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      cnt_tc = 1'b1;
      cycle();
      cnt_tc = 1'b0;
      check($sformatf("ss_tick%0d", p), {31'd0, tick}, 32'd1);
      if (p < 2) begin
        check($sformatf("ss_still_enabled%0d", p), {31'd0, cnt_en_n}, 32'd1 - 32'd1);
        cycle();
        check($sformatf("ss_gap_no_tick%0d", p), {31'd0, tick}, 32'd0);
      end
    end
    check("ss_en_n_high_after_final_tc", {31'd0, cnt_en_n}, 32'd1);
    check("ss_next_state", {29'd0, dbg_state}, {29'd0, ST_NEXT});
    check("ss_no_done_yet", {31'd0, done}, 32'd0);
    cycle();
    check("ss_done_pulse", {31'd0, done}, 32'd1);
    cycle();
    check("ss_done_cleared", {31'd0, done}, 32'd0);
    check("ss_busy_fell", {31'd0, busy}, 32'd0);
    check("ss_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("ss_ticks", tick_seen - t0, 3);

    // Table-driven runs
    for (int k = 0; k < 5; k++) run_vec(k);

    // Loop, then abort in RUN together with cnt_tc
    write_entry(2'd0, 8'h10, 1'b0, 4'd1, 1'b1);
    write_entry(2'd1, 8'h20, 1'b1, 4'd1, 1'b1);
    last_step = 2'd1; loop = 1'b1;
    push_load(2'd0); push_load(2'd1); push_load(2'd0);
    t0 = tick_seen; d0 = done_seen; l0 = load_seen;
    start = 1'b1;
    cycle();
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      cnt_tc = (cnt_en_n === 1'b0);
      cycle();
      if (load_seen - l0 >= 3) reached = 1'b1;
    end
    cnt_tc = 1'b0;
    check("loop_reload_entry0", {31'd0, reached}, 32'd1);
    check("loop_reload_step_idx", {30'd0, step_idx}, 32'd0);
    cycle();
    check("loop_run_again", {29'd0, dbg_state}, {29'd0, ST_RUN});
    abort  = 1'b1;
    cnt_tc = 1'b1;
    cycle();
    abort  = 1'b0;
    cnt_tc = 1'b0;
    check("abort_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_en_n", {31'd0, cnt_en_n}, 32'd1);
    check("abort_load_n", {31'd0, cnt_load_n}, 32'd1);
    check("abort_no_tick", {31'd0, tick}, 32'd0);
    check("abort_step_idx", {30'd0, step_idx}, 32'd0);
    cycle();
    check("abort_stays_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("loop_abort_no_done", done_seen - d0, 0);
    check("loop_abort_ticks", tick_seen - t0, 2);
    check("loop_abort_queue_empty", exp_q.size(), 0);

    // Config lockout: a write during the run must not land
    last_step = 2'd0; loop = 1'b0;
    push_load(2'd0);
    t0 = tick_seen;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("lock_busy", {31'd0, busy}, 32'd1);
    write_entry(2'd0, 8'hAA, 1'b1, 4'd7, 1'b0);
    run_until_done("lock_run1", 1'b0, 500);
    push_load(2'd0);
    run_until_done("lock_run2", 1'b0, 500);
    check("lock_ticks", tick_seen - t0, 2);
    check("lock_queue_empty", exp_q.size(), 0);

    // Terminal counts in IDLE are ignored
    cnt_tc = 1'b1;
    cycle();
    check("idle_tc_no_tick0", {31'd0, tick}, 32'd0);
    cycle();
    check("idle_tc_no_tick1", {31'd0, tick}, 32'd0);
    check("idle_tc_still_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    cnt_tc = 1'b0;

    // Reset in the middle of a sequence, then confirm the table was cleared
    write_entry(2'd0, 8'h40, 1'b1, 4'd5, 1'b1);
    push_load(2'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check("midrst_running", {29'd0, dbg_state}, {29'd0, ST_RUN});
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check("midrst_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_en_n", {31'd0, cnt_en_n}, 32'd1);
    check("midrst_cnt_data", {24'd0, cnt_data}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      sh_div[i] = '0; sh_dir[i] = 1'b0; sh_rep[i] = '0;
    end
    last_step = 2'd0;
    push_load(2'd0);
    t0 = tick_seen; d0 = done_seen;
    run_until_done("cleared_table", 1'b0, 200);
    check("cleared_table_no_ticks", tick_seen - t0, 0);
    check("cleared_table_done", done_seen - d0, 1);
    check("cleared_table_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
